// File: rtl/dist_entry_pkg.sv
// Shared types and constants for the keypad distance entry block.
// FSM state enum plus digit, accumulator and output widths.
package dist_entry_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIST_W     = 33;
  localparam int ACC_W      = 14;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [2:0] CNT_MAX = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

endpackage

// File: rtl/dist_entry_mul10_add.sv
// Combinational acc*10 + digit step for decimal-to-binary conversion.
// Ports: acc_i (ACC_W), digit_i (4) -> sum_o (ACC_W).
module mul10_add
  import dist_entry_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] dig_ext;

  assign dig_ext = {{(ACC_W-4){1'b0}}, digit_i};

  assign sum_o = (acc_i << 3)
               + (acc_i << 1)
               + dig_ext;

endmodule

// File: rtl/dist_entry.sv
// Keypad distance entry: BCD digit echo plus 4-digit decimal-to-binary.
// Ports: clk, rst_n, digit_in/valid, clear, enter -> bcd_*, busy, dist_*, err.
module dist_entry
  import dist_entry_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        digit_in,
  input  logic              digit_valid,
  input  logic              clear,
  input  logic              enter,
  output logic [3:0]        bcd_ones,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_hundreds,
  output logic [3:0]        bcd_thous,
  output logic              busy,
  output logic [DIST_W-1:0] dist_out,
  output logic              dist_valid,
  output logic              err
);

  state_e            state_q, state_d;
  digits_t           ent_q, ent_d;
  digits_t           cnv_q, cnv_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        step_q, step_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_nxt;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              busy_q, busy_d;
  logic              dv_q, dv_d;
  logic              err_q, err_d;

  mul10_add u_mul10 (
    .acc_i   (acc_q),
    .digit_i (cnv_q[NUM_DIGITS-1]),
    .sum_o   (acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    cnv_d   = cnv_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    acc_d   = acc_q;
    dist_d  = dist_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          ent_d = '0;
          cnt_d = '0;
        end else if (enter) begin
          cnv_d   = ent_q;
          acc_d   = '0;
          step_d  = '0;
          state_d = CONV;
          busy_d  = 1'b1;
          ent_d   = '0;
          cnt_d   = '0;
        end else if (digit_valid) begin
          if (digit_in <= BCD_MAX) begin
            ent_d = {ent_q[NUM_DIGITS-2:0], digit_in};
            if (cnt_q != CNT_MAX)
              cnt_d = cnt_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CONV: begin
        if (clear) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d  = acc_nxt;
          cnv_d  = {cnv_q[NUM_DIGITS-2:0], 4'd0};
          step_d = step_q + 2'd1;
          if (step_q == 2'd3)
            state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!clear) begin
          dist_d = {{(DIST_W-ACC_W){1'b0}}, acc_q};
          dv_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ent_q   <= '0;
      cnv_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      dist_q  <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      cnv_q   <= cnv_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      dist_q  <= dist_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign bcd_ones     = ent_q[0];
  assign bcd_tens     = ent_q[1];
  assign bcd_hundreds = ent_q[2];
  assign bcd_thous    = ent_q[3];
  assign busy         = busy_q;
  assign dist_out     = dist_q;
  assign dist_valid   = dv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_dist_entry.sv
// Directed self-checking bench for dist_entry.
// One task per scenario; inline comparisons; single summary line.
module tb_dist_entry;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        clear;
  logic        enter;
  logic [3:0]  bcd_ones;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_hundreds;
  logic [3:0]  bcd_thous;
  logic        busy;
  logic [32:0] dist_out;
  logic        dist_valid;
  logic        err;

  int checks;
  int failures;

  dist_entry dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .clear        (clear),
    .enter        (enter),
    .bcd_ones     (bcd_ones),
    .bcd_tens     (bcd_tens),
    .bcd_hundreds (bcd_hundreds),
    .bcd_thous    (bcd_thous),
    .busy         (busy),
    .dist_out     (dist_out),
    .dist_valid   (dist_valid),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_in    = d;
    digit_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  // mode 0: plain; 1: digits/enter injected while busy; 2: clear at E2
  task automatic run_enter(
    input  int          mode,
    output int          first,
    output int          npulse,
    output int          nerr,
    output logic        b0,
    output logic        b2,
    output logic [32:0] dv
  );
    first  = 0;
    npulse = 0;
    nerr   = 0;
    b2     = 1'b0;
    dv     = '0;
    @(negedge clk);
    enter = 1'b1;
    @(posedge clk);
    #1;
    b0 = busy;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      enter       = 1'b0;
      digit_valid = 1'b0;
      clear       = 1'b0;
      if (mode == 1 && e == 2) begin
        digit_valid = 1'b1;
        digit_in    = 4'd5;
        enter       = 1'b1;
      end
      if (mode == 1 && e == 3) begin
        digit_valid = 1'b1;
        digit_in    = 4'hC;
      end
      if (mode == 2 && e == 2)
        clear = 1'b1;
      @(posedge clk);
      #1;
      if (dist_valid) begin
        npulse++;
        if (first == 0) begin
          first = e + 1;
          dv    = dist_out;
        end
      end
      if (err)
        nerr++;
      if (e == 2)
        b2 = busy;
    end
    @(negedge clk);
    enter       = 1'b0;
    digit_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    digit_in    = '0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    enter       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bcd_thous, bcd_hundreds, bcd_tens, bcd_ones} !== 16'h0
        || busy !== 1'b0 || dist_out !== 33'd0
        || dist_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: bcd=%h busy=%b dist=%0d dv=%b err=%b want all 0",
        {bcd_thous, bcd_hundreds, bcd_tens, bcd_ones},
        busy, dist_out, dist_valid, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty_enter;
    int f, n, ne;
    logic b0, b2;
    logic [32:0] dv;
    run_enter(0, f, n, ne, b0, b2, dv);
    checks++;
    if (f !== 6 || n !== 1 || dv !== 33'd0) begin
      failures++;
      $display("FAIL empty_enter: lat=%0d pulses=%0d dist=%0d want 6/1/0",
        f, n, dv);
    end
  endtask

  task automatic test_1234;
    int f, n, ne;
    logic b0, b2;
    logic [32:0] dv;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    checks++;
    if ({bcd_thous, bcd_hundreds, bcd_tens, bcd_ones} !== 16'h1234) begin
      failures++;
      $display("FAIL echo_1234: got %h want 1234",
        {bcd_thous, bcd_hundreds, bcd_tens, bcd_ones});
    end
    run_enter(0, f, n, ne, b0, b2, dv);
    checks++;
    if (b0 !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_e0: got %b want 1", b0);
    end
    checks++;
    if (f !== 6 || n !== 1) begin
      failures++;
      $display("FAIL lat_1234: lat=%0d pulses=%0d want 6/1", f, n);
    end
    checks++;
    if (dv !== 33'd1234 || dist_out !== 33'd1234) begin
      failures++;
      $display("FAIL dist_1234: got %0d/%0d want 1234", dv, dist_out);
    end
    checks++;
    if ({bcd_thous, bcd_hundreds, bcd_tens, bcd_ones} !== 16'h0
        || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_1234: bcd=%h busy=%b want 0000/0",
        {bcd_thous, bcd_hundreds, bcd_tens, bcd_ones}, busy);
    end
  endtask

  task automatic test_clear_abort;
    int f, n, ne;
    logic b0, b2;
    logic [32:0] dv;
    press(4'd4);
    press(4'd2);
    run_enter(2, f, n, ne, b0, b2, dv);
    checks++;
    if (b2 !== 1'b0 || n !== 0) begin
      failures++;
      $display("FAIL clear_abort: busy_e2=%b pulses=%0d want 0/0", b2, n);
    end
    checks++;
    if (dist_out !== 33'd1234) begin
      failures++;
      $display("FAIL abort_hold: got %0d want 1234", dist_out);
    end
  endtask

  task automatic test_overflow_entry;
    int f, n, ne;
    logic b0, b2;
    logic [32:0] dv;
    press(4'd9);
    press(4'd8);
    press(4'd7);
    press(4'd6);
    press(4'd5);
    checks++;
    if ({bcd_thous, bcd_hundreds, bcd_tens, bcd_ones} !== 16'h8765) begin
      failures++;
      $display("FAIL echo_8765: got %h want 8765",
        {bcd_thous, bcd_hundreds, bcd_tens, bcd_ones});
    end
    run_enter(0, f, n, ne, b0, b2, dv);
    checks++;
    if (f !== 6 || dv !== 33'd8765) begin
      failures++;
      $display("FAIL dist_8765: lat=%0d got %0d want 6/8765", f, dv);
    end
    for (int i = 0; i < 4; i++)
      press(4'd9);
    run_enter(0, f, n, ne, b0, b2, dv);
    checks++;
    if (f !== 6 || dv !== 33'd9999) begin
      failures++;
      $display("FAIL dist_9999: lat=%0d got %0d want 6/9999", f, dv);
    end
  endtask

  task automatic test_err;
    press(4'd3);
    @(negedge clk);
    digit_in    = 4'hA;
    digit_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || bcd_ones !== 4'd3 || bcd_tens !== 4'd0) begin
      failures++;
      $display("FAIL err_pulse: err=%b ones=%0d tens=%0d want 1/3/0",
        err, bcd_ones, bcd_tens);
    end
    @(negedge clk);
    digit_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_width: err=%b want 0", err);
    end
  endtask

  task automatic test_enter_vs_digit;
    int f, n;
    @(negedge clk);
    digit_in    = 4'd7;
    digit_valid = 1'b1;
    enter       = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || bcd_ones !== 4'd0) begin
      failures++;
      $display("FAIL enter_wins: busy=%b ones=%0d want 1/0", busy, bcd_ones);
    end
    @(negedge clk);
    digit_valid = 1'b0;
    enter       = 1'b0;
    f = 0;
    n = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (dist_valid && f == 0) begin
        f = e + 1;
        n = int'(dist_out);
      end
    end
    checks++;
    if (f !== 6 || n !== 3) begin
      failures++;
      $display("FAIL dist_3: lat=%0d got %0d want 6/3", f, n);
    end
  endtask

  task automatic test_busy_ignore;
    int f, n, ne;
    logic b0, b2;
    logic [32:0] dv;
    press(4'd2);
    press(4'd6);
    run_enter(1, f, n, ne, b0, b2, dv);
    checks++;
    if (n !== 1 || ne !== 0 || dv !== 33'd26) begin
      failures++;
      $display("FAIL busy_ignore: pulses=%0d errs=%0d dist=%0d want 1/0/26",
        n, ne, dv);
    end
    checks++;
    if ({bcd_thous, bcd_hundreds, bcd_tens, bcd_ones} !== 16'h0) begin
      failures++;
      $display("FAIL busy_entry: got %h want 0000",
        {bcd_thous, bcd_hundreds, bcd_tens, bcd_ones});
    end
  endtask

  task automatic test_reset_mid;
    int f, n, ne;
    logic b0, b2;
    logic [32:0] dv;
    press(4'd5);
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dist_out !== 33'd0 || dist_valid !== 1'b0
        || bcd_ones !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b dist=%0d dv=%b ones=%0d want 0",
        busy, dist_out, dist_valid, bcd_ones);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_enter(0, f, n, ne, b0, b2, dv);
    checks++;
    if (f !== 6 || n !== 1 || dv !== 33'd0) begin
      failures++;
      $display("FAIL post_reset_enter: lat=%0d pulses=%0d dist=%0d want 6/1/0",
        f, n, dv);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_empty_enter();
    test_1234();
    test_clear_abort();
    test_overflow_entry();
    test_err();
    test_enter_vs_digit();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dist_entry.md
# dist_entry

Keypad-side distance entry block: accepts BCD digits one at a time, echoes the entered digits for the seven-segment display path, and on command converts the four-digit decimal entry into a binary distance. It performs the decimal-to-binary conversion, the reverse of the binary-to-digit split used by the display. It sits between the keypad scanner and the distance-consuming logic.

## Interface
- NUM_DIGITS, 4, decimal digits held and converted (MSD = thous)
- DIST_W, 33, width of binary distance output
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- digit_in  in  4  BCD digit from keypad
- digit_valid  in  1  single-cycle strobe qualifying digit_in
- clear  in  1  discard entry / abort conversion
- enter  in  1  start conversion of current entry
- bcd_ones, bcd_tens, bcd_hundreds, bcd_thous  out  4 each  current entered digits, for display echo
- busy  out  1  conversion in progress
- dist_out  out  DIST_W  last converted distance, held until next conversion
- dist_valid  out  1  one-cycle pulse, dist_out just updated
- err  out  1  one-cycle pulse, digit_in > 9 rejected

## Operation
- States: IDLE, CONV, DONE.
- Reset: state IDLE; all bcd_* = 0; digit count = 0; dist_out = 0; busy, dist_valid, err = 0; accumulator = 0.
- IDLE, priority clear > enter > digit_valid:
  - clear: all bcd_* <= 0, count <= 0; dist_out unchanged.
  - enter: latch digits into conversion shift register, acc <= 0, step <= 0, go CONV; bcd_* then cleared, count <= 0.
  - digit_valid, digit_in ≤ 9: shift entry left (thous <= hundreds, hundreds <= tens, tens <= ones, ones <= digit_in); count saturates at 4; with 4 digits already held the old thous digit is discarded.
  - digit_valid, digit_in > 9: entry unchanged, err = 1 for one cycle.
- CONV: each cycle acc <= acc*10 + next digit, MSD first (thous, hundreds, tens, ones); after the 4th step go DONE.
- DONE: dist_out <= zero-extended acc, dist_valid pulse, go IDLE.
- Arithmetic: acc is 14 bits (max 9999, no overflow); ×10 as (acc<<3)+(acc<<1); dist_out upper DIST_W-14 bits always 0.
- enter with count 0 converts all-zero digits: dist_out = 0, dist_valid pulses normally.
- busy = 1 in CONV and DONE. While busy, digit_valid and enter are ignored (no err, no entry change). clear while busy aborts: go IDLE next edge, no dist_valid, dist_out unchanged.
- Reset asserted mid-conversion: immediate return to reset values, including dist_out = 0.

## Timing
- Edge E0 samples enter → busy high after E0.
- Edges E1–E4: four accumulate steps; state DONE after E4.
- Edge E5: dist_out updated, dist_valid high for the cycle after E5 only, busy low after E5.
- Minimum enter-to-dist_valid latency: 6 edges counting E0; next enter accepted at E6.
- Digit entry: bcd_* update on the edge sampling digit_valid; err is registered, high for the cycle after that edge.
- Simultaneous digit_valid and enter in IDLE: enter wins, digit dropped.

## Structure
- Shared package: state enum (IDLE, CONV, DONE), constants NUM_DIGITS, DIST_W, ACC_W = 14, BCD_MAX = 9.
- One sub-module: mul10_add (ACC_W acc, 4-bit digit → ACC_W result, combinational), instantiated once in the CONV datapath.
- Top holds FSM, entry shift register, count, conversion digit shift register, output registers.

## Test plan
- Reset: hold rst_n low mid-run → all outputs 0, state IDLE; release, enter → dist_valid pulse with dist_out = 0.
- Digits 1,2,3,4 then enter → bcd_thous..ones = 1,2,3,4 before enter; dist_out = 1234 and dist_valid one cycle, 6 edges after enter edge.
- Digits 9,8,7,6,5 then enter → first 9 dropped, display 8,7,6,5, dist_out = 8765; digits 9,9,9,9 → 9999.
- digit_in = 4'hA with digit_valid → err one cycle, bcd_* unchanged; enter same cycle as digit 7 → digit ignored.
- Enter 42, clear at E2 of conversion → no dist_valid, dist_out keeps previous 1234, busy low after next edge.
- digit_valid and enter during busy → ignored, single dist_valid, entry empty afterwards.
